// File: rtl/moore_mode_fsm_pkg.sv
// Shared definitions for the Moore mode controller.
//   state_e  : FSM state encoding (IDLE/QUAL/PASS/SEL), STATE_W bits
//   is_sel() : returns the mode bit (MSB) of a command code
package moore_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        PASS = 2'd2,
        SEL  = 2'd3
    } state_e;

    // Mode bit of a code of width w (code is zero-extended into 32 bits).
    function automatic logic is_sel(input logic [31:0] code, input int w);
        return code[w-1];
    endfunction

endpackage

// File: rtl/moore_mode_fsm_if.sv
// Bus between the pad-level input decoder and the mode controller.
//   en     : sample enable (0 freezes the controller)
//   code   : command code, MSB = mode bit, all-zero = idle request
//   select : external value shown on K in select mode
//   K      : Moore output
//   valid  : a code is committed (PASS or SEL)
//   qual   : a code is being qualified
interface moore_mode_fsm_if #(
    parameter int CODE_W = 3,
    parameter int OUT_W  = CODE_W - 1
) ();
    logic              en;
    logic [CODE_W-1:0] code;
    logic [OUT_W-1:0]  select;
    logic [OUT_W-1:0]  K;
    logic              valid;
    logic              qual;

    modport master (output en, code, select, input K, valid, qual);
    modport slave  (input en, code, select, output K, valid, qual);
endinterface

// File: rtl/moore_mode_fsm_code_qualifier.sv
// Debounce for the command code: tracks the current candidate code and how
// many consecutive enabled samples it has been seen.
//   clk, reset_n : clock, async active-low reset
//   en           : sample enable; 0 holds cand and cnt
//   code         : raw command code
//   restart      : reload the candidate from code (FSM is not qualifying)
//   match_done   : code equals cand and this sample reaches HOLD_CYC
//   cand         : current candidate code
module code_qualifier #(
    parameter int CODE_W   = 3,
    parameter int HOLD_CYC = 4,
    parameter int CNT_W    = $clog2(HOLD_CYC + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    input  logic              restart,
    output logic              match_done,
    output logic [CODE_W-1:0] cand
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(HOLD_CYC);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand <= '0;
            cnt  <= '0;
        end else if (en) begin
            if (restart || code != cand) begin
                // A fresh nonzero code counts as its first sample.
                cand <= code;
                cnt  <= (code != '0) ? CNT_W'(1) : '0;
            end else if (cnt != FULL) begin
                cnt <= cnt + 1'b1;   // saturates at HOLD_CYC
            end
        end
    end

    // This sample is the HOLD_CYC-th consecutive one: cnt + 1 >= HOLD_CYC.
    assign match_done = (code == cand) && (code != '0) && (cnt >= LAST);

endmodule

// File: rtl/moore_mode_fsm.sv
// Moore mode controller. A command code that stays stable for HOLD_CYC
// enabled samples is committed; its MSB picks pass-through (K = code low
// bits) or select mode (K = registered external select). All outputs are
// registers.
//   clk     : system clock, rising edge
//   reset_n : async active-low reset
//   bus     : slave side of moore_mode_fsm_if (en, code, select, K, valid, qual)
module moore_mode_fsm
    import moore_pkg::*;
#(
    parameter int CODE_W   = 3,
    parameter int OUT_W    = CODE_W - 1,
    parameter int HOLD_CYC = 4,
    parameter int CNT_W    = $clog2(HOLD_CYC + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    moore_mode_fsm_if.slave bus
);

    logic              en;
    logic [CODE_W-1:0] code;
    logic [OUT_W-1:0]  select;

    assign en     = bus.en;
    assign code   = bus.code;
    assign select = bus.select;

    state_e            state;
    logic [CODE_W-1:0] act;
    logic [OUT_W-1:0]  sel_q;
    logic [OUT_W-1:0]  k_q;
    logic              valid_q;
    logic              qual_q;

    logic              match_done;
    logic [CODE_W-1:0] cand;
    logic              restart;

    // The qualifier only counts while in QUAL; elsewhere it tracks code so
    // that entering QUAL starts with cand = code, cnt = 1.
    assign restart = (state != QUAL);

    code_qualifier #(
        .CODE_W   (CODE_W),
        .HOLD_CYC (HOLD_CYC),
        .CNT_W    (CNT_W)
    ) u_qual (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .code       (code),
        .restart    (restart),
        .match_done (match_done),
        .cand       (cand)
    );

    // Commit decision. With HOLD_CYC == 1 a new nonzero code is already
    // qualified on its first sample, so it commits without visiting QUAL.
    logic              do_commit;
    logic [CODE_W-1:0] commit_code;

    always_comb begin
        do_commit   = 1'b0;
        commit_code = cand;
        case (state)
            IDLE: begin
                if (HOLD_CYC == 1 && code != '0) begin
                    do_commit   = 1'b1;
                    commit_code = code;
                end
            end
            QUAL: begin
                if (code != '0 && match_done) do_commit = 1'b1;
            end
            PASS, SEL: begin
                if (HOLD_CYC == 1 && code != '0 && code != act) begin
                    do_commit   = 1'b1;
                    commit_code = code;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            act     <= '0;
            sel_q   <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            qual_q  <= 1'b0;
        end else if (en) begin
            if (do_commit) begin
                act     <= commit_code;
                sel_q   <= select;
                valid_q <= 1'b1;
                qual_q  <= 1'b0;
                if (is_sel(32'(commit_code), CODE_W)) begin
                    state <= SEL;
                    k_q   <= select;
                end else begin
                    state <= PASS;
                    k_q   <= commit_code[OUT_W-1:0];
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (code != '0) begin
                            state  <= QUAL;
                            qual_q <= 1'b1;
                        end
                    end
                    QUAL: begin
                        // Mismatch reload and counting live in the qualifier.
                        if (code == '0) begin
                            state  <= IDLE;
                            qual_q <= 1'b0;
                        end
                    end
                    PASS, SEL: begin
                        if (code == '0) begin
                            state   <= IDLE;
                            act     <= '0;
                            k_q     <= '0;
                            valid_q <= 1'b0;
                        end else if (code != act) begin
                            state   <= QUAL;
                            k_q     <= '0;
                            valid_q <= 1'b0;
                            qual_q  <= 1'b1;
                        end else if (state == SEL) begin
                            // select reaches K one enabled edge later.
                            sel_q <= select;
                            k_q   <= select;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        act     <= '0;
                        k_q     <= '0;
                        valid_q <= 1'b0;
                        qual_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.K     = k_q;
    assign bus.valid = valid_q;
    assign bus.qual  = qual_q;

endmodule

// File: tb/tb_moore_mode_fsm.sv
// Directed bench for moore_mode_fsm: a HOLD_CYC=4 instance driven from a
// vector table plus hand-written reset/HOLD_CYC=1 sequences.
module tb_moore_mode_fsm;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    moore_mode_fsm_if #(.CODE_W(3), .OUT_W(2)) if4 ();
    moore_mode_fsm_if #(.CODE_W(3), .OUT_W(2)) if1 ();

    moore_mode_fsm #(.CODE_W(3), .OUT_W(2), .HOLD_CYC(4)) u4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if4)
    );

    moore_mode_fsm #(.CODE_W(3), .OUT_W(2), .HOLD_CYC(1)) u1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if1)
    );

    typedef struct {
        logic       en;
        logic [2:0] code;
        logic [1:0] sel;
        logic [1:0] k;
        logic       valid;
        logic       qual;
        string      name;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    task automatic add(input logic en, input logic [2:0] code, input logic [1:0] sel,
                       input logic [1:0] k, input logic valid, input logic qual,
                       input string name);
        vec_t v;
        v.en = en; v.code = code; v.sel = sel;
        v.k = k; v.valid = valid; v.qual = qual; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        // Basic pass-through commit after 4 samples, then exit.
        add(1, 3'b011, 2'b00, 2'b00, 0, 1, "pass_e1");
        add(1, 3'b011, 2'b00, 2'b00, 0, 1, "pass_e2");
        add(1, 3'b011, 2'b00, 2'b00, 0, 1, "pass_e3");
        add(1, 3'b011, 2'b00, 2'b11, 1, 0, "pass_commit");
        add(1, 3'b000, 2'b00, 2'b00, 0, 0, "pass_exit");
        // Restart: 011 twice, then 010 needs its own 4 samples.
        add(1, 3'b011, 2'b00, 2'b00, 0, 1, "rst_a1");
        add(1, 3'b011, 2'b00, 2'b00, 0, 1, "rst_a2");
        add(1, 3'b010, 2'b00, 2'b00, 0, 1, "rst_b1");
        add(1, 3'b010, 2'b00, 2'b00, 0, 1, "rst_b2");
        add(1, 3'b010, 2'b00, 2'b00, 0, 1, "rst_b3");
        add(1, 3'b010, 2'b00, 2'b10, 1, 0, "rst_b4_commit");
        add(1, 3'b000, 2'b00, 2'b00, 0, 0, "rst_exit");
        // Select mode, select tracking, freeze of select.
        add(1, 3'b101, 2'b01, 2'b00, 0, 1, "sel_e1");
        add(1, 3'b101, 2'b01, 2'b00, 0, 1, "sel_e2");
        add(1, 3'b101, 2'b01, 2'b00, 0, 1, "sel_e3");
        add(1, 3'b101, 2'b01, 2'b01, 1, 0, "sel_commit");
        add(1, 3'b101, 2'b11, 2'b11, 1, 0, "sel_track");
        add(0, 3'b101, 2'b00, 2'b11, 1, 0, "sel_frz1");
        add(0, 3'b101, 2'b10, 2'b11, 1, 0, "sel_frz2");
        add(1, 3'b101, 2'b10, 2'b10, 1, 0, "sel_resume");
        // New nonzero code from SEL goes back to qualification.
        add(1, 3'b011, 2'b10, 2'b00, 0, 1, "sel_to_qual");
        add(1, 3'b000, 2'b00, 2'b00, 0, 0, "qual_to_idle");
        // Freeze in QUAL at cnt=2, then 2 more edges to commit.
        add(1, 3'b001, 2'b00, 2'b00, 0, 1, "frz_e1");
        add(1, 3'b001, 2'b00, 2'b00, 0, 1, "frz_e2");
        for (int i = 0; i < 5; i++)
            add(0, 3'b001, 2'b00, 2'b00, 0, 1, "frz_hold");
        add(1, 3'b001, 2'b00, 2'b00, 0, 1, "frz_e3");
        add(1, 3'b001, 2'b00, 2'b01, 1, 0, "frz_commit");
        add(1, 3'b000, 2'b00, 2'b00, 0, 0, "frz_exit");

        if4.en = 1'b0; if4.code = '0; if4.select = '0;
        if1.en = 1'b0; if1.code = '0; if1.select = '0;
        reset_n = 1'b0;
        step();
        step();
        chk("reset_K", int'(if4.K), 0);
        chk("reset_valid", int'(if4.valid), 0);
        chk("reset_qual", int'(if4.qual), 0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            if4.en = vecs[i].en;
            if4.code = vecs[i].code;
            if4.select = vecs[i].sel;
            step();
            chk({vecs[i].name, "_K"}, int'(if4.K), int'(vecs[i].k));
            chk({vecs[i].name, "_valid"}, int'(if4.valid), int'(vecs[i].valid));
            chk({vecs[i].name, "_qual"}, int'(if4.qual), int'(vecs[i].qual));
        end

        // Reset mid-SEL with K=10 clears outputs without a clock edge.
        if4.en = 1'b1; if4.code = 3'b101; if4.select = 2'b10;
        for (int i = 0; i < 4; i++) step();
        chk("midsel_K", int'(if4.K), 2);
        chk("midsel_valid", int'(if4.valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_K", int'(if4.K), 0);
        chk("async_rst_valid", int'(if4.valid), 0);
        if4.code = 3'b000;
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_valid", int'(if4.valid), 0);
        chk("post_rst_qual", int'(if4.qual), 0);
        if4.code = 3'b011;
        step();
        chk("post_rst_to_qual", int'(if4.qual), 1);

        // Reset mid-qualification drops qual immediately.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_qual", int'(if4.qual), 0);
        if4.code = 3'b000; if4.en = 1'b0;
        step();
        reset_n = 1'b1;

        // HOLD_CYC=1: single-edge commit.
        if1.en = 1'b1; if1.code = 3'b001;
        step();
        chk("h1_pass_K", int'(if1.K), 1);
        chk("h1_pass_valid", int'(if1.valid), 1);
        chk("h1_pass_qual", int'(if1.qual), 0);
        if1.code = 3'b000;
        step();
        chk("h1_exit_K", int'(if1.K), 0);
        chk("h1_exit_valid", int'(if1.valid), 0);
        if1.code = 3'b100; if1.select = 2'b11;
        step();
        chk("h1_sel_K", int'(if1.K), 3);
        chk("h1_sel_valid", int'(if1.valid), 1);
        if1.select = 2'b01;
        step();
        chk("h1_sel_track", int'(if1.K), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
